// File: rtl/time_set_ctrl.sv
// Button-driven time-setting controller: debounces mode/inc/dec buttons and walks
// the user through the four BCD digits of a 24-hour time, driving the counter load port.

module time_set_ctrl_db #(
    parameter int DEBOUNCE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_press
);
    localparam int CW = $clog2(DEBOUNCE + 1);

    logic          r_s1, r_s2, r_f, r_fd;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_f   <= 1'b0;
            r_fd  <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_s1 <= i_btn;
            r_s2 <= r_s1;
            r_fd <= r_f;
            if (r_s2 == r_f) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE - 1)) begin
                // Accept the new level on the DEBOUNCE-th consecutive differing edge
                r_f   <= r_s2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_press = r_f & ~r_fd;
endmodule

module time_set_ctrl #(
    parameter int DEBOUNCE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic [4:0] i_hours,
    input  logic [5:0] i_minutes,
    output logic       normal_en,
    output logic [1:0] o_hours_left,
    output logic [3:0] o_hours_right,
    output logic [2:0] o_minutes_left,
    output logic [3:0] o_minutes_right,
    output logic [1:0] o_sel,
    output logic       o_setting
);
    localparam logic [2:0] S_RUN = 3'd0;
    localparam logic [2:0] S_HL  = 3'd1;
    localparam logic [2:0] S_HR  = 3'd2;
    localparam logic [2:0] S_ML  = 3'd3;
    localparam logic [2:0] S_MR  = 3'd4;

    logic [2:0] w_btn, w_press;
    logic       w_mode, w_inc, w_dec;

    assign w_btn = {btn_dec, btn_inc, btn_mode};

    time_set_ctrl_db #(.DEBOUNCE(DEBOUNCE)) u_db [2:0] (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (w_btn),
        .o_press (w_press)
    );

    // mode beats inc/dec; inc+dec together cancel
    assign w_mode = w_press[0];
    assign w_inc  = w_press[1] & ~w_press[2] & ~w_mode;
    assign w_dec  = w_press[2] & ~w_press[1] & ~w_mode;

    logic [2:0] r_state;
    logic       r_setting;
    logic [1:0] r_sel, r_hl;
    logic [3:0] r_hr, r_mr;
    logic [2:0] r_ml;

    logic [1:0] w_h_tens;
    logic [3:0] w_h_ones;
    logic [2:0] w_m_tens;
    logic [3:0] w_m_ones;
    logic       w_h_ok, w_m_ok;

    assign w_h_ok   = (i_hours <= 5'd23);
    assign w_m_ok   = (i_minutes <= 6'd59);
    assign w_h_tens = (i_hours >= 5'd20) ? 2'd2 : (i_hours >= 5'd10) ? 2'd1 : 2'd0;
    assign w_m_tens = (i_minutes >= 6'd50) ? 3'd5 : (i_minutes >= 6'd40) ? 3'd4 :
                      (i_minutes >= 6'd30) ? 3'd3 : (i_minutes >= 6'd20) ? 3'd2 :
                      (i_minutes >= 6'd10) ? 3'd1 : 3'd0;
    // Remainder is < 10, so 4-bit modular subtraction is exact
    assign w_h_ones = i_hours[3:0] - 4'(5'd10 * {3'b000, w_h_tens});
    assign w_m_ones = i_minutes[3:0] - 4'(6'd10 * {3'b000, w_m_tens});

    logic [3:0] w_hr_max;
    assign w_hr_max = (r_hl == 2'd2) ? 4'd3 : 4'd9;

    logic [2:0] w_state_nxt;
    logic [1:0] w_hl_nxt;
    logic [3:0] w_hr_nxt, w_mr_nxt;
    logic [2:0] w_ml_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_hl_nxt    = r_hl;
        w_hr_nxt    = r_hr;
        w_ml_nxt    = r_ml;
        w_mr_nxt    = r_mr;
        if (w_mode) begin
            case (r_state)
                S_RUN: begin
                    w_state_nxt = S_HL;
                    w_hl_nxt    = w_h_ok ? w_h_tens : 2'd0;
                    w_hr_nxt    = w_h_ok ? w_h_ones : 4'd0;
                    w_ml_nxt    = w_m_ok ? w_m_tens : 3'd0;
                    w_mr_nxt    = w_m_ok ? w_m_ones : 4'd0;
                end
                S_HL:    w_state_nxt = S_HR;
                S_HR:    w_state_nxt = S_ML;
                S_ML:    w_state_nxt = S_MR;
                default: w_state_nxt = S_RUN;
            endcase
        end else if (w_inc || w_dec) begin
            case (r_state)
                S_HL: begin
                    if (w_inc) w_hl_nxt = (r_hl >= 2'd2) ? 2'd0 : r_hl + 2'd1;
                    else       w_hl_nxt = (r_hl == 2'd0) ? 2'd2 : r_hl - 2'd1;
                    if (w_hl_nxt == 2'd2 && r_hr > 4'd3) w_hr_nxt = 4'd3;
                end
                S_HR: begin
                    if (w_inc) w_hr_nxt = (r_hr >= w_hr_max) ? 4'd0 : r_hr + 4'd1;
                    else       w_hr_nxt = (r_hr == 4'd0) ? w_hr_max : r_hr - 4'd1;
                end
                S_ML: begin
                    if (w_inc) w_ml_nxt = (r_ml >= 3'd5) ? 3'd0 : r_ml + 3'd1;
                    else       w_ml_nxt = (r_ml == 3'd0) ? 3'd5 : r_ml - 3'd1;
                end
                S_MR: begin
                    if (w_inc) w_mr_nxt = (r_mr >= 4'd9) ? 4'd0 : r_mr + 4'd1;
                    else       w_mr_nxt = (r_mr == 4'd0) ? 4'd9 : r_mr - 4'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_RUN;
            r_setting <= 1'b0;
            r_sel     <= 2'd0;
            r_hl      <= 2'd0;
            r_hr      <= 4'd0;
            r_ml      <= 3'd0;
            r_mr      <= 4'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_setting <= (w_state_nxt != S_RUN);
            r_sel     <= (w_state_nxt == S_RUN) ? 2'd0 : 2'(w_state_nxt - 3'd1);
            r_hl      <= w_hl_nxt;
            r_hr      <= w_hr_nxt;
            r_ml      <= w_ml_nxt;
            r_mr      <= w_mr_nxt;
        end
    end

    assign normal_en       = r_setting;
    assign o_setting       = r_setting;
    assign o_sel           = r_sel;
    assign o_hours_left    = r_hl;
    assign o_hours_right   = r_hr;
    assign o_minutes_left  = r_ml;
    assign o_minutes_right = r_mr;
endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl: directed walk plus random presses against a digit-level model.

module tb_time_set_ctrl;
    localparam int DB = 2;

    logic       clk = 1'b0, rst = 1'b0;
    logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
    logic [4:0] i_hours = '0;
    logic [5:0] i_minutes = '0;
    logic       normal_en, o_setting;
    logic [1:0] o_hours_left, o_sel;
    logic [3:0] o_hours_right, o_minutes_right;
    logic [2:0] o_minutes_left;

    time_set_ctrl #(.DEBOUNCE(DB)) dut (
        .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .i_hours(i_hours), .i_minutes(i_minutes), .normal_en(normal_en),
        .o_hours_left(o_hours_left), .o_hours_right(o_hours_right),
        .o_minutes_left(o_minutes_left), .o_minutes_right(o_minutes_right),
        .o_sel(o_sel), .o_setting(o_setting)
    );

    always #5 clk = ~clk;

    typedef struct { string name; logic [16:0] exp; } exp_t;
    exp_t q[$];
    exp_t mon_e;
    int   checks = 0, errors = 0;

    // Model: mode 0 = running, 1..4 = editing digit mode-1
    int m_st = 0;
    int m_d[4] = '{0, 0, 0, 0};

    wire [16:0] act = {normal_en, o_setting, o_sel, o_hours_left, o_hours_right,
                       o_minutes_left, o_minutes_right};

    function automatic logic [16:0] pack_model();
        logic       s;
        logic [1:0] sel;
        s   = (m_st != 0);
        sel = (m_st == 0) ? 2'd0 : 2'(m_st - 1);
        return {s, s, sel, 2'(m_d[0]), 4'(m_d[1]), 3'(m_d[2]), 4'(m_d[3])};
    endfunction

    function automatic int maxd(int idx);
        case (idx)
            0: return 2;
            1: return (m_d[0] == 2) ? 3 : 9;
            2: return 5;
            default: return 9;
        endcase
    endfunction

    task automatic model_apply(input bit m, input bit i, input bit d);
        int h, mi, idx, mx;
        if (m) begin
            if (m_st == 0) begin
                h  = (int'(i_hours) > 23) ? 0 : int'(i_hours);
                mi = (int'(i_minutes) > 59) ? 0 : int'(i_minutes);
                m_d[0] = h / 10;  m_d[1] = h % 10;
                m_d[2] = mi / 10; m_d[3] = mi % 10;
            end
            m_st = (m_st + 1) % 5;
            return;
        end
        if (m_st == 0 || i == d) return;
        idx = m_st - 1;
        mx  = maxd(idx);
        if (i) m_d[idx] = (m_d[idx] >= mx) ? 0 : m_d[idx] + 1;
        else   m_d[idx] = (m_d[idx] == 0) ? mx : m_d[idx] - 1;
        if (idx == 0 && m_d[0] == 2 && m_d[1] > 3) m_d[1] = 3;
    endtask

    task automatic expect_now(input string n);
        exp_t e;
        e.name = n;
        e.exp  = pack_model();
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            mon_e = q.pop_front();
            checks++;
            if (act !== mon_e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", mon_e.name, act, mon_e.exp);
            end
        end
    end

    task automatic press(input bit m, input bit i, input bit d, input int hold, input string n);
        @(negedge clk);
        btn_mode = m; btn_inc = i; btn_dec = d;
        repeat (hold) @(negedge clk);
        btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        repeat (8) @(negedge clk);
        model_apply(m, i, d);
        expect_now(n);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int r;
        repeat (3) @(negedge clk);
        expect_now("reset_state");
        @(negedge clk);
        #2 rst = 1'b1;
        repeat (4) @(negedge clk);
        expect_now("idle");

        // One-cycle glitch must be filtered
        @(negedge clk) btn_mode = 1'b1;
        @(negedge clk) btn_mode = 1'b0;
        repeat (8) @(negedge clk);
        expect_now("glitch");

        // Latency: action lands exactly on edge DB+3
        i_hours = 5'd17; i_minutes = 6'd42;
        @(negedge clk) btn_mode = 1'b1;
        repeat (DB + 2) @(posedge clk);
        #1 expect_now("latency_before");
        @(posedge clk);
        model_apply(1'b1, 1'b0, 1'b0);
        #1 expect_now("latency_at");
        repeat (4) @(negedge clk);
        btn_mode = 1'b0;
        repeat (8) @(negedge clk);
        expect_now("seed_17_42");

        press(0, 1, 0, 6, "hl_inc_clamp");
        press(0, 1, 0, 6, "hl_inc_wrap");
        press(0, 0, 1, 6, "hl_dec_wrap");
        press(1, 0, 0, 6, "to_hr");
        press(0, 1, 0, 6, "hr_inc_wrap3");
        press(1, 0, 0, 6, "to_ml");
        press(0, 1, 0, 6, "ml_inc");
        press(0, 1, 0, 6, "ml_inc_wrap");
        press(1, 0, 0, 6, "to_mr");
        press(0, 0, 1, 6, "mr_dec");
        press(0, 0, 1, 6, "mr_dec0");
        press(0, 0, 1, 6, "mr_dec_wrap");
        press(0, 1, 1, 6, "inc_dec_drop");
        press(1, 1, 0, 12, "mode_inc_exit");
        press(0, 1, 0, 6, "run_inc_ignored");

        // Reset mid-edit in SET_ML
        press(1, 0, 0, 6, "enter_hl");
        press(1, 0, 0, 6, "enter_hr");
        press(1, 0, 0, 6, "enter_ml");
        @(posedge clk);
        #2 rst = 1'b0;
        m_st = 0; m_d = '{0, 0, 0, 0};
        expect_now("reset_mid_edit");
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        i_hours = 5'd9; i_minutes = 6'd5;
        press(1, 0, 0, 6, "reseed_9_05");
        i_hours = 5'd30; i_minutes = 6'd61;
        press(1, 0, 0, 6, "exit_hr");
        press(1, 0, 0, 6, "exit_ml");
        press(1, 0, 0, 6, "exit_mr");
        press(1, 0, 0, 6, "exit_run");
        press(1, 0, 0, 6, "seed_out_of_range");

        for (int k = 0; k < 60; k++) begin
            i_hours   = 5'($urandom_range(0, 31));
            i_minutes = 6'($urandom_range(0, 63));
            r = $urandom_range(0, 19);
            if (r < 6)       press(1, 0, 0, $urandom_range(6, 14), "rand_mode");
            else if (r < 12) press(0, 1, 0, $urandom_range(6, 14), "rand_inc");
            else if (r < 17) press(0, 0, 1, $urandom_range(6, 14), "rand_dec");
            else if (r < 18) press(0, 1, 1, $urandom_range(6, 14), "rand_incdec");
            else             press(1, 0, 1, $urandom_range(6, 14), "rand_modedec");
        end

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
